// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 boot loader: loader FSM states, word width,
// default memory address width and the HLT opcode.
package mips32_pkg;

  localparam int WORD_W         = 32;
  localparam int ADDR_W_DEFAULT = 10;

  // Opcode field of the HLT instruction.
  localparam logic [5:0] OP_HLT = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_RUN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mips32_prog_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words. It can also zero-fill a
// partial word on request, and it registers the finished word with a valid pulse.
module byte_packer
  import mips32_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        data,
  input  logic              pad,
  input  logic              wr_allow,
  output logic [1:0]        byte_idx,
  output logic              word_done,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_q
);

  // asm_q holds up to three earlier bytes, with the newest byte in the low bits.
  logic [23:0]       asm_q;
  logic [WORD_W-1:0] word_next;

  always_comb begin
    word_done = 1'b0;
    word_next = '0;
    if (push && (byte_idx == 2'd3)) begin
      word_done = 1'b1;
      word_next = {asm_q, data};
    end else if (pad) begin
      word_done = (byte_idx != 2'd0);
      case (byte_idx)
        2'd1:    word_next = {asm_q[7:0], 24'h000000};
        2'd2:    word_next = {asm_q[15:0], 16'h0000};
        2'd3:    word_next = {asm_q, 8'h00};
        default: word_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      asm_q      <= '0;
      word_valid <= 1'b0;
      word_q     <= '0;
    end else begin
      word_valid <= word_done && wr_allow;
      if (word_done && wr_allow)
        word_q <= word_next;
      if (clear) begin
        byte_idx <= 2'd0;
        asm_q    <= '0;
      end else if (push) begin
        byte_idx <= byte_idx + 2'd1;
        asm_q    <= {asm_q[15:0], data};
      end else if (pad) begin
        byte_idx <= 2'd0;
        asm_q    <= '0;
      end
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader that streams a program into MIPS32 memory from word 0, then runs the CPU until it halts.
// Defining LOADER_CHECKSUM_EN makes the s_last byte a checksum that is checked before the CPU is released.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic [ADDR_W:0]   load_words,
  output logic              err_overflow,
  output logic              err_csum
);

  // state | meaning
  // IDLE  | waiting for start, stream blocked
  // LOAD  | accepting bytes, writing each completed word
  // PAD   | zero-filling and writing the trailing partial word
  // RUN   | CPU released until it reports halt

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e state;
  logic [1:0]    byte_idx;
  logic          word_done;
  logic          accept;
  logic          push;
  logic          pad;
  logic          clear;
  logic          full;
  logic          pend_after;
  logic          stop;
  logic          pad_to_idle;

  assign accept = s_valid && s_ready;
  assign full   = (load_words == DEPTH);
  assign pad    = (state == ST_PAD);
  assign clear  = (state == ST_IDLE) && start;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;
  logic       csum_bad;

  // The checksum byte is not program data and never enters the packer.
  assign push       = accept && !s_last;
  assign csum_bad   = ((csum_acc + s_data) != 8'h00);
  assign pend_after = (byte_idx != 2'd0);
  assign stop       = err_overflow || csum_bad;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      csum_acc <= 8'h00;
      err_csum <= 1'b0;
    end else if (clear) begin
      csum_acc <= 8'h00;
      err_csum <= 1'b0;
    end else if (push) begin
      csum_acc <= csum_acc + s_data;
    end else if (accept && s_last && csum_bad) begin
      err_csum <= 1'b1;
    end
  end
`else
  assign push       = accept;
  assign pend_after = (byte_idx != 2'd3);
  assign stop       = err_overflow || full;
  assign err_csum   = 1'b0;
`endif

  byte_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clear      (clear),
    .push       (push),
    .data       (s_data),
    .pad        (pad),
    .wr_allow   (!full),
    .byte_idx   (byte_idx),
    .word_done  (word_done),
    .word_valid (mem_we),
    .word_q     (mem_wdata)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      s_ready      <= 1'b0;
      mem_addr     <= '0;
      load_words   <= '0;
      cpu_run      <= 1'b0;
      err_overflow <= 1'b0;
      pad_to_idle  <= 1'b0;
    end else begin
      if (word_done && !full) begin
        mem_addr   <= load_words[ADDR_W-1:0];
        load_words <= load_words + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LOAD;
            s_ready      <= 1'b1;
            load_words   <= '0;
            err_overflow <= 1'b0;
            pad_to_idle  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (push && full)
              err_overflow <= 1'b1;
            if (s_last) begin
              s_ready <= 1'b0;
              // A partial word can only be written while memory still has room.
              if (pend_after && !full) begin
                state       <= ST_PAD;
                pad_to_idle <= stop;
              end else begin
                state <= stop ? ST_IDLE : ST_RUN;
              end
            end
          end
        end
        ST_PAD: begin
          state <= pad_to_idle ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (!cpu_run) begin
            cpu_run <= 1'b1;
          end else if (cpu_halted) begin
            cpu_run <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: a byte-queue model checks the outputs every cycle, and literal values pin the model.
`timescale 1ns/1ps
module tb_mips32_prog_loader;
  localparam int DEPTH = 1024;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, s_valid = 1'b0, s_last = 1'b0, cpu_halted = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, mem_we, cpu_run, err_overflow, err_csum;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] load_words;

  logic        start2 = 1'b0, s_valid2 = 1'b0, s_last2 = 1'b0;
  logic [7:0]  s_data2 = 8'h00;
  logic        s_ready2, mem_we2, cpu_run2, err_overflow2, err_csum2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  load_words2;

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.ADDR_W(10)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .load_words(load_words), .err_overflow(err_overflow), .err_csum(err_csum)
  );

  mips32_prog_loader #(.ADDR_W(2)) dut2 (
    .clk1(clk1), .rst_n(rst_n), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .s_last(s_last2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .cpu_run(cpu_run2), .cpu_halted(1'b0),
    .load_words(load_words2), .err_overflow(err_overflow2), .err_csum(err_csum2)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the bytes of the current load are kept in a queue, and each group of four becomes a write.
  typedef enum {M_IDLE, M_LOAD, M_PAD, M_RUN} mphase_e;
  mphase_e     ph = M_IDLE;
  logic [7:0]  mb[$];
  logic        e_ready = 1'b0, e_we = 1'b0, e_run = 1'b0, e_ovf = 1'b0;
  logic [9:0]  e_addr = '0;
  logic [31:0] e_wdata = '0;
  int          e_words = 0;

  function automatic logic [31:0] pack_at(input int base);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      w = {w[23:0], (base + k < mb.size()) ? mb[base + k] : 8'h00};
    return w;
  endfunction

  function automatic void model_write(input int base);
    e_we    = 1'b1;
    e_addr  = e_words[9:0];
    e_wdata = pack_at(base);
    e_words = e_words + 1;
  endfunction

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ph = M_IDLE; mb.delete();
      e_ready = 0; e_we = 0; e_run = 0; e_ovf = 0; e_addr = '0; e_wdata = '0; e_words = 0;
    end else begin
      e_we = 1'b0;
      case (ph)
        M_IDLE: if (start) begin
          ph = M_LOAD; e_ready = 1'b1; mb.delete(); e_words = 0; e_ovf = 1'b0;
        end
        M_LOAD: if (s_valid && e_ready) begin
          mb.push_back(s_data);
          if (e_words == DEPTH) e_ovf = 1'b1;
          else if (mb.size() % 4 == 0) model_write(mb.size() - 4);
          if (s_last) begin
            e_ready = 1'b0;
            if (e_ovf) ph = M_IDLE;
            else if (mb.size() % 4 == 0) ph = M_RUN;
            else ph = M_PAD;
          end
        end
        M_PAD: begin
          model_write(mb.size() - (mb.size() % 4));
          ph = M_RUN;
        end
        M_RUN: begin
          if (!e_run) e_run = 1'b1;
          else if (cpu_halted) begin e_run = 1'b0; ph = M_IDLE; end
        end
      endcase
    end
  end

  always @(negedge clk1) begin
    chk("s_ready", s_ready, e_ready);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_run", cpu_run, e_run);
    chk("load_words", load_words, e_words);
    chk("err_overflow", err_overflow, e_ovf);
    chk("err_csum", err_csum, 0);
  end

  // Memory image and write counters, sampled at the edge that ends each cycle.
  logic [31:0] img[0:15];
  int          nwr = 0;
  logic [1:0]  a2q[$];
  logic [31:0] d2q[$];
  logic        run2_seen = 1'b0;

  always @(posedge clk1) begin
    if (mem_we === 1'b1) begin img[mem_addr[3:0]] = mem_wdata; nwr++; end
    if (mem_we2 === 1'b1) begin a2q.push_back(mem_addr2); d2q.push_back(mem_wdata2); end
    if (cpu_run2 === 1'b1) run2_seen = 1'b1;
  end

  task automatic pulse_start();
    start = 1'b1; @(negedge clk1); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gap);
    int n;
    n = 0;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk1);
    s_valid = 1'b1; s_data = b; s_last = last;
    while (s_ready !== 1'b1 && n < 20) begin @(negedge clk1); n++; end
    if (n >= 20) chk("ready_timeout", s_ready, 1);
    @(negedge clk1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_run !== 1'b1 && n < 20) begin @(negedge clk1); n++; end
    chk("cpu_run_rise", cpu_run, 1);
  endtask

  task automatic halt();
    cpu_halted = 1'b1; @(negedge clk1); cpu_halted = 1'b0;
    chk("cpu_run_fall", cpu_run, 0);
    @(negedge clk1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] t1[8];
    logic [7:0] t2[6];
    t1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00};
    t2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

    repeat (3) @(negedge clk1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_load_words", load_words, 0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Full words only, then halt.
    base = nwr;
    pulse_start();
    chk("ready_after_start", s_ready, 1);
    for (int i = 0; i < 8; i++) send(t1[i], i == 7, 0);
    wait_run();
    chk("t1_writes", nwr - base, 2);
    chk("t1_word0", img[0], 32'h00000001);
    chk("t1_word1", img[1], 32'hFC000000);
    chk("t1_load_words", load_words, 2);
    halt();

    // Trailing partial word goes through PAD.
    base = nwr;
    pulse_start();
    for (int i = 0; i < 6; i++) send(t2[i], i == 5, 0);
    wait_run();
    chk("t2_writes", nwr - base, 2);
    chk("t2_word0", img[0], 32'hAABBCCDD);
    chk("t2_word1", img[1], 32'h11220000);
    halt();

    // Reset after two bytes discards the partial word.
    base = nwr;
    pulse_start();
    send(8'h12, 1'b0, 0);
    send(8'h34, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_load_words", load_words, 0);
    @(negedge clk1); @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    chk("mid_rst_no_write", nwr - base, 0);
    pulse_start();
    send(8'hDE, 1'b0, 0); send(8'hAD, 1'b0, 0); send(8'hBE, 1'b0, 0); send(8'hEF, 1'b1, 0);
    wait_run();
    chk("t3_writes", nwr - base, 1);
    chk("t3_word0", img[0], 32'hDEADBEEF);
    chk("t3_addr", mem_addr, 0);
    halt();

    // Random valid gaps, with start pulses in LOAD and in RUN.
    base = nwr;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      if (i == 5) pulse_start();
      send(8'h10 + 8'(i), i == 11, $urandom_range(0, 2));
    end
    wait_run();
    pulse_start();
    chk("run_start_ignored", cpu_run, 1);
    chk("t4_load_words", load_words, 3);
    chk("t4_writes", nwr - base, 3);
    chk("t4_word0", img[0], 32'h10111213);
    chk("t4_word2", img[2], 32'h18191A1B);
    halt();

    // Overflow on a 4-word memory.
    start2 = 1'b1; @(negedge clk1); start2 = 1'b0;
    chk("ovf_ready", s_ready2, 1);
    for (int i = 0; i < 20; i++) begin
      s_valid2 = 1'b1; s_data2 = 8'(i); s_last2 = (i == 19);
      @(negedge clk1);
    end
    s_valid2 = 1'b0; s_last2 = 1'b0;
    repeat (3) @(negedge clk1);
    chk("ovf_writes", a2q.size(), 4);
    for (int i = 0; i < a2q.size() && i < 4; i++) chk("ovf_addr", a2q[i], i);
    if (d2q.size() == 4) begin
      chk("ovf_word0", d2q[0], 32'h00010203);
      chk("ovf_word3", d2q[3], 32'h0C0D0E0F);
    end
    chk("ovf_flag", err_overflow2, 1);
    chk("ovf_run_seen", run2_seen, 0);
    chk("ovf_ready_low", s_ready2, 0);
    chk("ovf_load_words", load_words2, 4);
    start2 = 1'b1; @(negedge clk1); start2 = 1'b0;
    chk("ovf_idle_restart", s_ready2, 1);
    chk("ovf_flag_cleared", err_overflow2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Boot-time program loader sitting directly upstream of the MIPS32 pipeline's instruction/data memory. It accepts a big-endian byte stream over a valid/ready handshake and packs it into 32-bit words. It writes those words sequentially into the shared 1024-word memory from address 0, then releases the processor by asserting `cpu_run` until the processor reports halt.

## Interface
- `ADDR_W`, 10: memory word-address width (depth 2^ADDR_W).
- `clk1` input 1: single clock (IF/EX/WB phase clock of the processor).
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a load from IDLE, ignored elsewhere.
- `s_valid` input 1: byte-stream valid.
- `s_ready` output 1: byte-stream ready.
- `s_data` input 8: stream byte; first byte of a word lands in bits 31:24.
- `s_last` input 1: marks the final byte of the program.
- `mem_we` output 1: memory write strobe, one cycle per word.
- `mem_addr` output ADDR_W: word address of the write.
- `mem_wdata` output 32: word written.
- `cpu_run` output 1: level; processor may execute while high (drives HALTED clear).
- `cpu_halted` input 1: processor has executed HLT.
- `load_words` output ADDR_W+1: words written in the current load.
- `err_overflow` output 1: sticky; bytes arrived beyond memory depth.
- `err_csum` output 1: sticky checksum failure (see Configuration).

## Operation
- FSM states: IDLE, LOAD, PAD, RUN.
- IDLE: `s_ready`=0. On `start`: clear `load_words`, byte index, errors, and checksum accumulator, then go to LOAD.
- LOAD: `s_ready`=1. A byte transfers when `s_valid` and `s_ready` are both high. Each byte shifts into a 32-bit assembly register and the byte index increments mod 4. On index 3 the word is latched into the write register and `mem_we` pulses the following cycle with `mem_addr`=`load_words`; `load_words` then increments.
- `s_last` accepted at index 3: the word is written normally, then the FSM goes to RUN.
- `s_last` accepted at index 0–2: go to PAD.
- PAD: remaining low bytes are zero-filled, and the word is written in the cycle after entering PAD. Then go to RUN. `s_ready`=0.
- Overflow: when `load_words` = 2^ADDR_W, further bytes are still accepted (the stream drains) but no write occurs. `err_overflow` sets. On `s_last`, the FSM returns to IDLE; RUN is never entered.
- RUN: `cpu_run`=1 and `s_ready`=0. On `cpu_halted`=1 the FSM goes to IDLE and `cpu_run` drops the next cycle.
- `start` during LOAD, PAD, or RUN is ignored.
- Reset mid-operation: any in-flight partial word is discarded and no write is issued.

## Timing
- Reset values: `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `load_words`=0, `err_overflow`=0, `err_csum`=0. The FSM resets to IDLE.
- All outputs are registered.
- `s_ready` rises the cycle after `start` is sampled.
- `mem_we` pulses exactly 1 cycle after the 4th byte of a word is accepted. Back-to-back bytes give one write every 4 cycles, and acceptance never stalls for the write.
- `cpu_run` rises 1 cycle after the final write's `mem_we` cycle. It falls 1 cycle after `cpu_halted` is sampled high.
- `load_words` updates in the same cycle as `mem_we`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The byte tagged `s_last` is a checksum byte, not program data.
  - Program bytes are added mod 256; the sum plus the checksum must equal 0x00.
  - Any partial word pending before the checksum byte is padded and written as in PAD.
  - On mismatch, `err_csum` sets and the FSM returns to IDLE without asserting `cpu_run`.
- Undefined: the `s_last` byte is ordinary data, and `err_csum` is constant 0.

## Structure
- Shared package `mips32_pkg`: the FSM state enumeration, `WORD_W`=32, the default `ADDR_W`, and the HLT opcode constant 6'b111111 used by benches.
- One natural sub-module, `byte_packer`: the 8-to-32 shift/assembly register with byte index, zero-pad request, and a word-valid pulse. The FSM, address counter, errors, and checksum stay in the top level.

## Test plan
- 8 bytes 00 00 00 01 / FC 00 00 00, `s_last` on the 8th, no backpressure → writes of 0x00000001 at address 0, then 0xFC000000 at address 1. `load_words`=2, `cpu_run`=1; assert `cpu_halted` → `cpu_run`=0 next cycle, state IDLE.
- 6 bytes AA BB CC DD 11 22, `s_last` on 22 → writes 0xAABBCCDD at address 0 and 0x11220000 at address 1 (PAD path).
- `ADDR_W`=2, 20 bytes → exactly 4 writes to addresses 0–3, `err_overflow`=1, `cpu_run` never asserted, state returns to IDLE.
- `rst_n` pulsed low after 2 bytes of a word → no `mem_we`, all outputs at reset values. A subsequent `start` plus 4 bytes writes to address 0.
- With `LOADER_CHECKSUM_EN`: bytes 01 02 03 04 plus checksum F6 → one write of 0x01020304, `cpu_run`=1. The same stream with checksum F7 → `err_csum`=1 and `cpu_run`=0.
- `start` pulsed while in LOAD and in RUN → ignored. `s_valid` toggled randomly → byte order preserved and the write count is correct.
